// File: rtl/cen_scheduler.sv
// Per-channel clock-enable divider with clear/preset hold sequencer; 1-cycle registered latency.
// No backpressure: requests are sampled every cycle and a newer request restarts the hold.
module cen_scheduler #(
    parameter int W    = 4,
    parameter int DIVW = 8,
    parameter int HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sync,
    input  logic [W*DIVW-1:0] period,
    input  logic [W-1:0]      clr_req,
    input  logic [W-1:0]      set_req,
    output logic [W-1:0]      cen,
    output logic [W-1:0]      clr,
    output logic [W-1:0]      set,
    output logic [W-1:0]      busy
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HOLD_CLR = 2'd1,
        HOLD_SET = 2'd2
    } state_e;

    for (genvar i = 0; i < W; i++) begin : g_ch
        state_e          state_q, state_d;
        logic [DIVW-1:0] cnt_q, cnt_d;
        logic [DIVW-1:0] per_raw, per_eff;
        logic [3:0]      hold_q, hold_d;
        logic            cen_q, cen_d;
        logic            clr_q, clr_d;
        logic            set_q, set_d;

        assign per_raw = period[i*DIVW +: DIVW];
        // A zero period would allow back-to-back strobes; clamp to 1.
        assign per_eff = (per_raw == '0) ? DIVW'(1) : per_raw;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            hold_d  = hold_q;
            cen_d   = 1'b0;
            clr_d   = 1'b0;
            set_d   = 1'b0;
            if (clr_req[i]) begin
                state_d = HOLD_CLR;
                hold_d  = 4'(HOLD);
                cnt_d   = '0;
                clr_d   = 1'b1;
            end else if (set_req[i]) begin
                state_d = HOLD_SET;
                hold_d  = 4'(HOLD);
                cnt_d   = '0;
                set_d   = 1'b1;
            end else begin
                case (state_q)
                    RUN: begin
                        if (sync) begin
                            cnt_d = '0;
                        end else if (enable) begin
                            if (cnt_q >= per_eff) begin
                                cnt_d = '0;
                                cen_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + DIVW'(1);
                            end
                        end
                    end
                    HOLD_CLR, HOLD_SET: begin
                        // hold_q counts the assertion cycles still owed, including the current one.
                        if (hold_q <= 4'd1) begin
                            state_d = RUN;
                            hold_d  = '0;
                            cnt_d   = '0;
                        end else begin
                            hold_d = hold_q - 4'd1;
                            clr_d  = (state_q == HOLD_CLR);
                            set_d  = (state_q == HOLD_SET);
                        end
                    end
                    default: begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= RUN;
                cnt_q   <= '0;
                hold_q  <= '0;
                cen_q   <= 1'b0;
                clr_q   <= 1'b0;
                set_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hold_q  <= hold_d;
                cen_q   <= cen_d;
                clr_q   <= clr_d;
                set_q   <= set_d;
            end
        end

        assign cen[i]  = cen_q;
        assign clr[i]  = clr_q;
        assign set[i]  = set_q;
        assign busy[i] = (state_q != RUN);
    end

endmodule

// File: tb/tb_cen_scheduler.sv
// Bench for cen_scheduler: table-driven hold sequences plus hand-written divider, sync, freeze and reset cases.
module tb_cen_scheduler;

    localparam int W    = 4;
    localparam int DIVW = 8;
    localparam int HOLD = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              sync;
    logic [W*DIVW-1:0] period;
    logic [W-1:0]      clr_req;
    logic [W-1:0]      set_req;
    logic [W-1:0]      cen;
    logic [W-1:0]      clr;
    logic [W-1:0]      set;
    logic [W-1:0]      busy;

    cen_scheduler #(.W(W), .DIVW(DIVW), .HOLD(HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .sync    (sync),
        .period  (period),
        .clr_req (clr_req),
        .set_req (set_req),
        .cen     (cen),
        .clr     (clr),
        .set     (set),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cen;
        logic [3:0] clr;
        logic [3:0] set;
        logic [3:0] busy;
        logic [3:0] m;
        string      name;
    } exp_t;

    typedef struct packed {
        logic       en;
        logic       sy;
        logic [3:0] cr;
        logic [3:0] sr;
        logic [3:0] cen;
        logic [3:0] clr;
        logic [3:0] set;
        logic [3:0] busy;
        logic [3:0] m;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[18];
    int   eff[4];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_out();
        exp_t       e;
        logic [15:0] act, want, mm;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: output cycle with no expectation queued");
        end else begin
            e    = sb.pop_front();
            act  = {cen, clr, set, busy};
            want = {e.cen, e.clr, e.set, e.busy};
            mm   = {e.m, e.m, e.m, e.m};
            if ((act & mm) !== (want & mm)) begin
                n_fail++;
                $display("FAIL %s: got cen=%b clr=%b set=%b busy=%b, want cen=%b clr=%b set=%b busy=%b (channels %b)",
                         e.name, cen, clr, set, busy, e.cen, e.clr, e.set, e.busy, e.m);
            end
        end
        n_checks++;
        if (((cen & clr) | (cen & set) | (clr & set)) !== 4'b0000) begin
            n_fail++;
            $display("FAIL exclusive: cen=%b clr=%b set=%b overlap, want none", cen, clr, set);
        end
    endtask

    task automatic step(input logic en, input logic sy, input logic [3:0] cr, input logic [3:0] sr,
                        input logic [3:0] ecen, input logic [3:0] eclr, input logic [3:0] eset,
                        input logic [3:0] ebusy, input logic [3:0] m, input string nm);
        exp_t e;
        enable  = en;
        sync    = sy;
        clr_req = cr;
        set_req = sr;
        e.cen = ecen; e.clr = eclr; e.set = eset; e.busy = ebusy; e.m = m; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Free run from a freshly zeroed counter: strobe on every (eff+1)-th cycle.
    task automatic run_free(input int n, input string nm);
        logic [3:0] ec;
        for (int k = 1; k <= n; k++) begin
            for (int c = 0; c < 4; c++) ec[c] = ((k % (eff[c] + 1)) == 0);
            step(1'b1, 1'b0, 4'b0, 4'b0, ec, 4'b0, 4'b0, 4'b0, 4'b1111, nm);
        end
    endtask

    task automatic check_zero(input string nm);
        n_checks++;
        if ({cen, clr, set, busy} !== 16'h0000) begin
            n_fail++;
            $display("FAIL %s: got cen=%b clr=%b set=%b busy=%b, want all 0", nm, cen, clr, set, busy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // en sy cr sr cen clr set busy mask
        tbl[0]  = '{1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0100};
        tbl[1]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0100};
        tbl[2]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0100};
        tbl[3]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0100};
        tbl[4]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        tbl[5]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        tbl[6]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        tbl[7]  = '{1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0001};
        tbl[8]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0001};
        tbl[9]  = '{1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
        tbl[10] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
        tbl[11] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
        tbl[12] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
        tbl[13] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        tbl[14] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        tbl[15] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        tbl[16] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        tbl[17] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};

        rst_n   = 1'b0;
        enable  = 1'b0;
        sync    = 1'b0;
        clr_req = '0;
        set_req = '0;
        period  = {8'd7, 8'd0, 8'd1, 8'd3};
        eff     = '{3, 1, 1, 7};
        #3;
        check_zero("reset_state");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero("reset_held");

        // Divider spacing 4/2/2/8 from reset release.
        rst_n = 1'b1;
        run_free(64, "divider");

        // Clear hold on channel 2, then clear-vs-set priority and set takeover on channel 0.
        for (int r = 0; r < 18; r++)
            step(tbl[r].en, tbl[r].sy, tbl[r].cr, tbl[r].sr, tbl[r].cen, tbl[r].clr,
                 tbl[r].set, tbl[r].busy, tbl[r].m, $sformatf("table_row%0d", r));

        // Staggered channels realigned by sync: all strobe together six cycles later.
        period = {4{8'd5}};
        step(1'b1, 1'b1, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b1111, "sync_edge");
        for (int k = 1; k <= 5; k++)
            step(1'b1, 1'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b1111, "sync_gap");
        step(1'b1, 1'b0, 4'b0, 4'b0, 4'b1111, 4'b0, 4'b0, 4'b0, 4'b1111, "sync_align");

        // Freeze with counters at 2, then resume from the frozen value.
        for (int k = 0; k < 2; k++)
            step(1'b1, 1'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b1111, "pre_freeze");
        for (int k = 0; k < 10; k++)
            step(1'b0, 1'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b1111, "frozen");
        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b1111, "resume");
        step(1'b1, 1'b0, 4'b0, 4'b0, 4'b1111, 4'b0, 4'b0, 4'b0, 4'b1111, "resume_cen");

        // Period shrinks below the running count: wrap and strobe at once.
        for (int k = 0; k < 4; k++)
            step(1'b1, 1'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b1111, "pre_shrink");
        period = {4{8'd2}};
        step(1'b1, 1'b0, 4'b0, 4'b0, 4'b1111, 4'b0, 4'b0, 4'b0, 4'b1111, "shrink_wrap");
        step(1'b1, 1'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b1111, "shrink_gap");
        step(1'b1, 1'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b1111, "shrink_gap");
        step(1'b1, 1'b0, 4'b0, 4'b0, 4'b1111, 4'b0, 4'b0, 4'b0, 4'b1111, "shrink_cen");

        // Reset lands between edges in hold cycle 2: outputs drop without a clock.
        step(1'b1, 1'b0, 4'b0010, 4'b1000, 4'b0, 4'b0010, 4'b1000, 4'b1010, 4'b1010, "hold_c1");
        step(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0, 4'b0010, 4'b1000, 4'b1010, 4'b1010, "hold_c2");
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_abort");
        @(posedge clk);
        #1;
        check_zero("abort_held");
        period = {8'd7, 8'd0, 8'd1, 8'd3};
        eff    = '{3, 1, 1, 7};
        rst_n  = 1'b1;
        run_free(24, "post_reset");

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cen_scheduler.md
CEN_SCHEDULER -- requirements
Module: cen_scheduler

Interface
REQ-001 SHALL have parameter W, default 4: number of independent flip-flop channels driven.
REQ-002 SHALL have parameter DIVW, default 8: width of each channel's period field.
REQ-003 SHALL have parameter HOLD, default 4: cycles a clear/preset pulse is held (legal range 1..15).
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  global run gate for the divider counters.
REQ-007 SHALL have port sync  input  1  single-cycle pulse that phase-aligns all channels.
REQ-008 SHALL have port period  input  W*DIVW  per-channel period minus one; channel i uses bits [i*DIVW +: DIVW].
REQ-009 SHALL have port clr_req  input  W  per-channel clear request, sampled every cycle.
REQ-010 SHALL have port set_req  input  W  per-channel preset request, sampled every cycle.
REQ-011 SHALL have port cen  output  W  registered clock-enable strobes for the downstream edge-detecting flip-flops.
REQ-012 SHALL have port clr  output  W  registered clear drive.
REQ-013 SHALL have port set  output  W  registered preset drive.
REQ-014 SHALL have port busy  output  W  high while the channel is in a hold state.

Function
REQ-015 Each channel SHALL be an independent FSM with states RUN, HOLD_CLR, HOLD_SET.
REQ-016 In RUN with enable=1, the channel counter SHALL increment each cycle; on reaching the effective period it SHALL wrap to 0 and drive cen high for exactly the following one cycle.
REQ-017 Effective period SHALL be max(period_i, 1), so cen is never high two consecutive cycles; the downstream flip-flop always sees a low cycle before each rising edge.
REQ-018 With enable=0 the counters SHALL hold their value and cen SHALL be 0; holds in progress SHALL still count down.
REQ-019 A change to period_i SHALL take effect at the next comparison; if the counter already exceeds the new period it SHALL wrap to 0 on the next cycle and generate cen.
REQ-020 clr_req_i=1 in any state SHALL move the channel to HOLD_CLR, load the hold counter with HOLD, and reset the divider counter to 0.
REQ-021 set_req_i=1 with clr_req_i=0 SHALL move the channel to HOLD_SET under the same rules. If both are high in the same cycle, clear SHALL win.
REQ-022 A new request arriving during a hold SHALL restart the hold counter at HOLD. The new request type SHALL replace the current one. Clear SHALL still take priority over set.
REQ-023 In HOLD_CLR the channel SHALL drive clr=1, set=0, cen=0 and busy=1. In HOLD_SET it SHALL drive set=1, clr=0, cen=0 and busy=1.
REQ-024 The hold SHALL last exactly HOLD cycles of output assertion. The channel SHALL then return to RUN with its counter at 0, so the first cen follows a full effective period later.
REQ-025 Requests SHALL produce their registered output one cycle after sampling, giving one cycle of latency.
REQ-026 sync=1 SHALL reset the divider counters of all RUN channels to 0 and suppress cen in the next cycle. Channels in a hold SHALL be unaffected by sync.
REQ-027 cen, clr and set SHALL never be high simultaneously on the same channel.

Reset
REQ-028 While rst_n=0, all channels SHALL be in RUN with counters at 0, and cen, clr, set and busy SHALL all be 0, asynchronously.
REQ-029 After rst_n deasserts, the first cen on channel i SHALL occur effective_period_i+1 cycles after the first enabled cycle.
REQ-030 Reset asserted mid-hold SHALL abort the hold immediately; clr and set SHALL fall without waiting for a clock edge.

Verification
REQ-031 Scenario: W=4, period={3,1,0,7}, enable=1 for 64 cycles -> cen pulse spacing of 4, 2, 2 and 8 cycles respectively, each pulse 1 cycle wide.
REQ-032 Scenario: clr_req[2] pulsed 1 cycle with HOLD=4 -> clr[2]=1 for cycles +1..+4, busy[2] matching, cen[2]=0 throughout; first cen[2] appears a full period after release.
REQ-033 Scenario: clr_req[0] and set_req[0] high in the same cycle -> only clr[0] asserts. set_req[0] at hold cycle 2 -> switches to set[0] and restarts 4 cycles.
REQ-034 Scenario: period=5 on all channels with channels staggered, then sync pulsed -> all cen coincide 6 cycles later.
REQ-035 Scenario: rst_n driven low at hold cycle 2 between clock edges -> clr/set/busy drop to 0 before the next edge; after release, cen timing matches REQ-029.
REQ-036 Scenario: enable=0 for 10 cycles mid-count -> no cen. Then enable=1 -> counting resumes from the frozen value; assertion REQ-027 is checked every cycle.
